// File: rtl/keccak_lane_responder.sv
// Lane-streaming front end for a Keccak-f[1600] engine: loads, permutes, unloads.
// Optional KECCAK_RESP_OVF_EN adds a sticky ovf_o for excess or short blocks.
module keccak_lane_responder #(
  parameter int W     = 64,
  parameter int LANES = 25
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [W-1:0]         din_i,
  input  logic                 din_valid_i,
  input  logic                 last_block_i,
  output logic                 ready_o,
  output logic                 perm_start_o,
  output logic [W*LANES-1:0]   perm_state_o,
  input  logic                 perm_done_i,
  input  logic [W*LANES-1:0]   perm_state_i,
  output logic [W-1:0]         dout_o,
  output logic                 dout_valid_o
`ifdef KECCAK_RESP_OVF_EN
  ,
  output logic                 ovf_o
`endif
);

  localparam int D_WIDTH = W * LANES;
  localparam int CW      = $clog2(LANES + 1);
  localparam logic [CW-1:0] FULL_C = CW'(LANES);
  localparam logic [CW-1:0] LAST_C = CW'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PERM,
    S_WAIT,
    S_UNLOAD
  } state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [LANES-1:0][W-1:0]     lane_q, lane_d;
`ifdef KECCAK_RESP_OVF_EN
  logic                        ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
`ifdef KECCAK_RESP_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          lane_d  = '0;
          cnt_d   = '0;
          state_d = S_LOAD;
`ifdef KECCAK_RESP_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (din_valid_i) begin
          if (cnt_q < FULL_C) begin
            lane_d[cnt_q] = din_i;
            cnt_d         = cnt_q + CW'(1);
          end
`ifdef KECCAK_RESP_OVF_EN
          else begin
            ovf_d = 1'b1;
          end
`endif
        end
        if (last_block_i) begin
          state_d = S_PERM;
`ifdef KECCAK_RESP_OVF_EN
          // short-block test uses the count after any same-cycle word
          if (cnt_d < FULL_C) ovf_d = 1'b1;
`endif
        end
      end
      S_PERM: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (perm_done_i) begin
          lane_d  = perm_state_i;
          cnt_d   = '0;
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
`ifdef KECCAK_RESP_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
`ifdef KECCAK_RESP_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    ready_o      = (state_q == S_IDLE);
    perm_start_o = (state_q == S_PERM);
    dout_valid_o = (state_q == S_UNLOAD);
    perm_state_o = D_WIDTH'(lane_q);
    dout_o       = dout_valid_o ? lane_q[cnt_q] : '0;
  end

`ifdef KECCAK_RESP_OVF_EN
  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_keccak_lane_responder.sv
// Randomized bench for keccak_lane_responder with a lane-list reference model.
// Build with KECCAK_RESP_OVF_EN to also check the ovf_o flag.
module tb_keccak_lane_responder;

  localparam int W = 64;
  localparam int L = 25;
  localparam int D = W * L;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [W-1:0] din_i;
  logic         din_valid_i;
  logic         last_block_i;
  logic         ready_o;
  logic         perm_start_o;
  logic [D-1:0] perm_state_o;
  logic         perm_done_i;
  logic [D-1:0] perm_state_i;
  logic [W-1:0] dout_o;
  logic         dout_valid_o;
`ifdef KECCAK_RESP_OVF_EN
  logic         ovf_o;
`endif

  int n_run = 0;
  int n_fail = 0;
  logic [W-1:0] words[$];

  always #5 clk = ~clk;

  keccak_lane_responder dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .din_i(din_i), .din_valid_i(din_valid_i),
    .last_block_i(last_block_i), .ready_o(ready_o),
    .perm_start_o(perm_start_o), .perm_state_o(perm_state_o),
    .perm_done_i(perm_done_i), .perm_state_i(perm_state_i),
    .dout_o(dout_o), .dout_valid_o(dout_valid_o)
`ifdef KECCAK_RESP_OVF_EN
    , .ovf_o(ovf_o)
`endif
  );

  task automatic check(input string tag,
                       input logic [D-1:0] got,
                       input logic [D-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      if (got[D-1:W] == '0 && exp[D-1:W] == '0)
        $display("FAIL %s got %h exp %h", tag, got[W-1:0], exp[W-1:0]);
      else
        $display("FAIL %s got/exp differ in wide value", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input int n, input bit gap,
                           input bit same, input bit spur,
                           input int rst_at);
    logic [D-1:0] exp_st;
    logic [D-1:0] mask;
    logic [D-1:0] exp_out;
    exp_st = '0;
    for (int i = 0; i < n && i < L; i++) exp_st[W*i +: W] = words[i];
    for (int i = 0; i < L; i++) mask[W*i +: W] = {$urandom, $urandom};
    exp_out = exp_st ^ mask;

    check("idle_ready", D'(ready_o), D'(1));
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("load_ready", D'(ready_o), D'(0));
    check("load_clear", perm_state_o, '0);
`ifdef KECCAK_RESP_OVF_EN
    check("ovf_clear", D'(ovf_o), D'(0));
`endif
    if (spur) begin
      perm_done_i  = 1'b1;
      perm_state_i = {L{64'hdead_beef_cafe_f00d}};
      tick();
      perm_done_i = 1'b0;
      check("spur_done_load", perm_state_o, '0);
    end
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        din_valid_i = 1'b0;
        din_i       = {$urandom, $urandom};
        tick();
      end
      din_valid_i  = 1'b1;
      din_i        = words[i];
      last_block_i = same && (i == n - 1);
      tick();
    end
    din_valid_i = 1'b0;
    if (!same) begin
      last_block_i = 1'b1;
      tick();
    end
    last_block_i = 1'b0;
    check("perm_start", D'(perm_start_o), D'(1));
    check("perm_state", perm_state_o, exp_st);
    if (spur) begin
      perm_done_i  = 1'b1;
      perm_state_i = ~exp_out;
    end
    tick();
    perm_done_i = 1'b0;
    check("perm_once", D'(perm_start_o), D'(0));
    check("wait_novalid", D'(dout_valid_o), D'(0));
    check("wait_hold", perm_state_o, exp_st);
    if (spur) begin
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("spur_start_wait", D'({ready_o, perm_start_o, dout_valid_o}), D'(0));
      check("spur_hold", perm_state_o, exp_st);
    end else begin
      tick();
    end
    perm_done_i  = 1'b1;
    perm_state_i = exp_out;
    tick();
    perm_done_i  = 1'b0;
    perm_state_i = '0;
    for (int k = 0; k < L; k++) begin
      check($sformatf("dv%0d", k), D'(dout_valid_o), D'(1));
      check($sformatf("dout%0d", k), D'(dout_o), D'(exp_out[W*k +: W]));
      check($sformatf("rdy%0d", k), D'(ready_o), D'(0));
      if (k == rst_at) begin
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("rst_dv", D'(dout_valid_o), D'(0));
        check("rst_ready", D'(ready_o), D'(1));
        check("rst_buf", perm_state_o, '0);
        check("rst_dout", D'(dout_o), D'(0));
        return;
      end
      tick();
    end
    check("end_dv", D'(dout_valid_o), D'(0));
    check("end_dout", D'(dout_o), D'(0));
    check("end_ready", D'(ready_o), D'(1));
`ifdef KECCAK_RESP_OVF_EN
    check("ovf", D'(ovf_o), D'(n != L));
`endif
  endtask

  task automatic fill(input int n, input bit pat);
    words.delete();
    for (int i = 0; i < n; i++)
      words.push_back(pat ? W'(i) * 64'h0101_0101_0101_0101
                          : {$urandom, $urandom});
  endtask

  initial begin
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    din_i        = '0;
    din_valid_i  = 1'b0;
    last_block_i = 1'b0;
    perm_done_i  = 1'b0;
    perm_state_i = '0;
    tick();
    tick();
    check("rst_ready0", D'(ready_o), D'(1));
    check("rst_start0", D'(perm_start_o), D'(0));
    check("rst_dv0", D'(dout_valid_o), D'(0));
    check("rst_dout0", D'(dout_o), D'(0));
    check("rst_state0", perm_state_o, '0);
    rst_ni = 1'b1;
    tick();

    fill(25, 1'b1); run_block(25, 1'b0, 1'b0, 1'b0, -1);
    fill(25, 1'b1); run_block(25, 1'b1, 1'b0, 1'b1, -1);
    fill(10, 1'b0); run_block(10, 1'b0, 1'b0, 1'b0, -1);
    fill(27, 1'b0); run_block(27, 1'b0, 1'b1, 1'b0, -1);
    fill(25, 1'b0); run_block(25, 1'b0, 1'b1, 1'b0, 12);
    fill(25, 1'b0); run_block(25, 1'b0, 1'b0, 1'b0, -1);
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(30, 1);
      fill(n, 1'b0);
      run_block(n, 1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
